// File: rtl/u2_to_zm_serial.sv
// Bit-serial two's complement to sign-magnitude converter; `U2ZM_SATURATE_EN saturates overflow instead of zeroing it.
// Latency: o_valid rises m-1 rising edges after the accepting edge; one operand per m+1 cycles at best.
// Backpressure: o_ready only in IDLE; result, status and o_valid are held in DONE until i_ready.
module u2_to_zm_serial #(
    parameter int m = 4,
    parameter int n = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [m-1:0] i_argA,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [m-1:0] o_result,
    output logic [n-1:0] o_status
);

    localparam int CW = (m > 2) ? $clog2(m - 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(m - 2);

    localparam logic [n-1:0] ST_POS  = n'(0);
    localparam logic [n-1:0] ST_NEG  = n'(1);
    localparam logic [n-1:0] ST_ZERO = n'(2);
    localparam logic [n-1:0] ST_OVF  = n'(3);

`ifdef U2ZM_SATURATE_EN
    localparam logic [m-1:0] OVF_RESULT = '1;
`else
    localparam logic [m-1:0] OVF_RESULT = '0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [m-2:0]  shreg_q, shreg_d;
    logic [m-2:0]  mag_q, mag_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sign_q, sign_d;
    logic          seen_one_q, seen_one_d;
    logic          valid_q, valid_d;
    logic [m-1:0]  result_q, result_d;
    logic [n-1:0]  status_q, status_d;

    logic          bit_in;
    logic          out_bit;
    logic          seen_one_nxt;
    logic [m-1:0]  mag_ext;
    logic [m-2:0]  mag_nxt;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        mag_d      = mag_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        seen_one_d = seen_one_q;
        valid_d    = valid_q;
        result_d   = result_q;
        status_d   = status_q;

        // Serial negation: copy bits up to and including the first one, invert the rest.
        bit_in       = shreg_q[0];
        out_bit      = (sign_q & seen_one_q) ? ~bit_in : bit_in;
        seen_one_nxt = seen_one_q | bit_in;
        mag_ext      = {out_bit, mag_q};
        mag_nxt      = mag_ext[m-1:1];

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    shreg_d    = i_argA[m-2:0];
                    sign_d     = i_argA[m-1];
                    seen_one_d = 1'b0;
                    cnt_d      = '0;
                    mag_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d    = shreg_q >> 1;
                seen_one_d = seen_one_nxt;
                mag_d      = mag_nxt;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    if (!sign_q) begin
                        result_d = seen_one_nxt ? {1'b0, mag_nxt} : '0;
                        status_d = seen_one_nxt ? ST_POS : ST_ZERO;
                    end else if (seen_one_nxt) begin
                        result_d = {1'b1, mag_nxt};
                        status_d = ST_NEG;
                    end else begin
                        result_d = OVF_RESULT;
                        status_d = ST_OVF;
                    end
                end
            end
            DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            mag_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            seen_one_q <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            mag_q      <= mag_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            seen_one_q <= seen_one_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            status_q   <= status_d;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_status = status_q;

endmodule

// File: doc/u2_to_zm_serial.md
Name: u2_to_zm_serial

Overview:
Bit-serial converter from two's complement (U2) to sign-magnitude (ZM). It is the inverse of the combinational ZM-to-U2 converter in the arithmetic block set. One m-bit operand is accepted through a valid/ready handshake and its magnitude bits are processed LSB-first, one per clock. The result is returned with a 2-bit status code on a second valid/ready handshake. It sits between the U2 arithmetic units (subtract, compare) and any consumer that needs ZM results.

Parameters:
m, 4, operand/result width in bits; legal range m >= 2.
n, 2, status width; fixed at 2, any other value is illegal.

Ports:
i_clk  input  1  clock; all state changes on the rising edge.
i_rst  input  1  synchronous reset, active-high.
i_valid  input  1  i_argA is valid.
o_ready  output  1  block can accept an operand.
i_argA  input  m  U2 operand.
o_valid  output  1  o_result and o_status are valid.
i_ready  input  1  consumer accepts the result.
o_result  output  m  ZM result: bit m-1 is the sign, bits m-2:0 are the magnitude.
o_status  output  2  00 positive non-zero, 01 negative, 10 zero, 11 overflow.

Behaviour:
- Interface: one clock, i_clk; reset i_rst is synchronous and active-high.
- Reset: state IDLE, o_valid=0, o_result='0, o_status=2'b00, o_ready=1. All internal registers are cleared.
- Reset mid-operation (SHIFT or DONE): the operation is aborted and no result is emitted. o_ready=1 in the cycle after the reset edge.
- FSM states: IDLE, SHIFT, DONE.
  - o_ready is 1 only in IDLE. It is decoded from the state register.
  - o_valid is registered and is 1 only in DONE.
- IDLE: when i_valid && o_ready:
  - capture i_argA into the shift register;
  - sign <= i_argA[m-1]; seen_one <= 0; cnt <= 0;
  - go to SHIFT.
  - With i_valid low, stay in IDLE.
- SHIFT: each cycle process bit b = operand[cnt], for cnt = 0 .. m-2:
  - If sign=0: out = b.
  - If sign=1: out = seen_one ? ~b : b (serial two's-complement negation).
  - seen_one <= seen_one | b; magnitude[cnt] <= out.
  - On the edge where cnt == m-2: go to DONE, set o_valid=1, and load o_result/o_status.
- Latency: o_valid is high exactly m-1 rising edges after the accepting edge (3 edges for m=4).
- Result and status rules (at the DONE load):
  - sign=0, operand lower bits all zero: o_result='0, o_status=10.
  - sign=0, non-zero: o_result={1'b0, magnitude}, o_status=00.
  - sign=1 and seen_one=1: o_result={1'b1, magnitude}, o_status=01.
  - sign=1 and seen_one=0 (input is 1 followed by zeros, i.e. -2^(m-1), not representable in ZM): overflow, o_status=11, o_result as defined under Optional Feature.
- DONE:
  - o_result, o_status and o_valid are held stable while i_ready=0, for any number of cycles.
  - On the edge where o_valid && i_ready: o_valid <= 0, go to IDLE.
  - o_result/o_status keep their last values after the handshake until the next DONE load.
- i_valid is ignored outside IDLE. The producer must hold i_argA until acceptance.
- Minimum throughput: one operand per m+1 cycles, since there is no overlap between DONE and the next acceptance.
- Negative zero never appears in o_result; zero is always all zeros.

Optional Feature:
Macro U2ZM_SATURATE_EN.
- Defined: on overflow, o_result = {1'b1, {(m-1){1'b1}}}, i.e. saturated to the most negative ZM value (-(2^(m-1)-1)); o_status=11.
- Not defined: on overflow, o_result='0; o_status=11.
- All other behaviour, including latency and the handshake, is identical in both builds.

Test Plan:
- m=4, i_argA=0101 (+5), i_ready=1 -> o_result=0101, o_status=00, o_valid high 3 edges after accept, low one cycle later, o_ready back to 1.
- i_argA=1011 (-5) -> o_result=1101, o_status=01. i_argA=1111 (-1) -> o_result=1001, o_status=01.
- i_argA=0000 -> o_result=0000, o_status=10.
- i_argA=1000 (-8) -> o_status=11. Without macro o_result=0000; with U2ZM_SATURATE_EN o_result=1111.
- Backpressure: i_argA=1110 (-2), hold i_ready=0 for 5 cycles in DONE -> o_result=1010, o_status=01 stable, o_ready=0; a new i_valid pulse with 0011 is not accepted. After i_ready=1 the next accepted 0011 gives 0011/00.
- Assert i_rst for one cycle at the second SHIFT cycle of 1011 -> o_valid never rises, o_result=0000, o_status=00, o_ready=1 after the reset edge; the next operand converts normally.
